// File: rtl/runner_up_change_reporter.sv
// runner_up_change_reporter
// Watches the runner-up value from the second-largest tracker and logs a
// {value, timestamp} event whenever it changes. Events queue in a small FIFO
// and drain to the reporting fabric. The upstream stream cannot be stalled,
// so events arriving at a full FIFO are dropped and counted.
//
// Output handshake: out_valid is high whenever the FIFO holds an event, and
// out_value/out_stamp then show the head event. A head event is consumed at
// a posedge where out_valid && out_ready. While out_valid=1 and out_ready=0
// the head event stays unchanged. out_ready is ignored while out_valid=0.
// out_valid never depends combinationally on out_ready.
module runner_up_change_reporter #(
    parameter int DATA_WIDTH  = 32,
    parameter int STAMP_WIDTH = 16,
    parameter int DEPTH       = 4,
    parameter int DROP_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_value,
    output logic [STAMP_WIDTH-1:0] out_stamp,
    output logic [$clog2(DEPTH):0] out_level,
    output logic                   overflow,
    output logic [DROP_WIDTH-1:0]  drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0]  prev;
    logic [STAMP_WIDTH-1:0] stamp;
    logic [DATA_WIDTH-1:0]  mem_value [DEPTH];
    logic [STAMP_WIDTH-1:0] mem_stamp [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          level;

    logic change;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Change detect and FIFO control. A pop in the same cycle frees a slot,
    // so a full FIFO still accepts the push when the head is being consumed.
    always_comb begin
        change = (din != prev);
        empty  = (level == '0);
        full   = (level == LW'(DEPTH));
        pop    = !empty && out_ready;
        push   = change && (!full || pop);
        drop   = change && full && !pop;
    end

    // Previous-value register and free-running wrapping timestamp.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev  <= '0;
            stamp <= '0;
        end else begin
            prev  <= din;
            stamp <= stamp + STAMP_WIDTH'(1);
        end
    end

    // Event storage; contents only matter at occupied slots, so no reset.
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem_value[wr_ptr] <= din;
            mem_stamp[wr_ptr] <= stamp;
        end
    end

    // Pointers and occupancy; level tracks push-only/pop-only edges.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow flag and saturating dropped-event counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != {DROP_WIDTH{1'b1}})
                drop_count <= drop_count + DROP_WIDTH'(1);
        end
    end

    // Head event straight from storage; forced to zero while empty.
    always_comb begin
        out_valid = !empty;
        out_level = level;
        out_value = empty ? '0 : mem_value[rd_ptr];
        out_stamp = empty ? '0 : mem_stamp[rd_ptr];
    end

endmodule

// File: doc/runner_up_change_reporter.md
Name: runner_up_change_reporter

Overview:
Downstream consumer of the second-largest tracker stage. Watches the tracker's running runner-up value every cycle. Each time the value changes, it logs a {value, timestamp} event into a small FIFO. Events drain to the reporting fabric over a valid/ready interface, and overflow is accounted for rather than stalling the upstream stream, which has no backpressure.

Parameters:
DATA_WIDTH, 32, width of the monitored value; must match the tracker's data width.
STAMP_WIDTH, 16, width of the free-running cycle timestamp.
DEPTH, 4, event FIFO depth; power of 2, at least 2.
DROP_WIDTH, 8, width of the saturating dropped-event counter.

Ports:
clk  in  1  clock.
resetn  in  1  synchronous active-low reset.
din  in  DATA_WIDTH  runner-up value from the tracker, sampled every cycle.
out_ready  in  1  consumer accepts the head event this cycle.
out_valid  out  1  head event present.
out_value  out  DATA_WIDTH  head event value.
out_stamp  out  STAMP_WIDTH  head event timestamp.
out_level  out  $clog2(DEPTH)+1  FIFO occupancy.
overflow  out  1  sticky: at least one event dropped since reset.
drop_count  out  DROP_WIDTH  dropped events, saturating at all-ones.

Behaviour:
- Reset (resetn=0 at posedge clk) clears the following:
  - prev=0, stamp counter=0, FIFO empty, out_valid=0, out_level=0, overflow=0, drop_count=0.
  - out_value and out_stamp read 0 while the FIFO is empty.
- Reset mid-operation discards all queued events and ends any partial handshake.
- Reset value of prev is 0, matching the tracker's reset, so no spurious event is generated after reset.
- Stamp counter: increments by 1 every non-reset cycle and wraps modulo 2^STAMP_WIDTH with no flag. Its value is 0 in the first cycle after reset.
- Change detect:
  - event(t) = (din != prev) at cycle t.
  - prev <= din every non-reset cycle.
  - The event carries {din, stamp(t)}, where stamp(t) is the counter value in the same cycle.
- Push: an event is written at the posedge ending cycle t.
  - Latency: event in cycle t -> out_valid=1 in cycle t+1 if the FIFO was empty.
  - No combinational din->out path.
- Pop: out_valid && out_ready at a posedge removes the head.
  - out_ready while out_valid=0 is ignored.
  - Outputs are held stable while out_valid=1 and out_ready=0.
- FIFO order: strictly FIFO. Head data is driven from registered storage at the read pointer.
- Pointers: log2(DEPTH)-bit read and write pointers wrap naturally. Full/empty are derived from out_level (0 = empty, DEPTH = full).
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - The push is accepted even when full, because the pop frees a slot in the same edge.
  - With level 1, the new event becomes head in the next cycle.
- Overflow: a push with level==DEPTH and no pop in the same cycle does the following:
  - The event is dropped; FIFO contents are unchanged.
  - overflow<=1, sticky until reset.
  - drop_count increments, saturating at 2^DROP_WIDTH-1.
- Consecutive identical din values produce no events. A return to an earlier value (A->B->A) produces an event on each change.
- out_level is updated on the same edge as push/pop: +1 push only, -1 pop only, 0 for both or neither.

Test Plan:
- Reset then din held at 0 for 10 cycles, out_ready=1 -> out_valid stays 0, out_level=0, overflow=0.
- din=0,0,5,5,9 starting at cycle 0 after reset, out_ready=1:
  - out_valid pulses in cycle 3 with {5,2} and in cycle 5 with {9,4}.
  - Each event pops in the cycle it appears.
- out_ready=0; din changes to 1,2,3,4,5,6 on consecutive cycles (DEPTH=4):
  - out_level reaches 4.
  - overflow=1, drop_count=2.
  - Draining yields values 1,2,3,4 in order with consecutive stamps.
- Full FIFO with out_ready=1 and a new event in the same cycle -> push accepted, level stays 4, drop_count unchanged, new event emerges last.
- 300 forced drops with DROP_WIDTH=8 -> drop_count saturates at 255, overflow=1.
- Let the stamp counter run to 2^STAMP_WIDTH-1, then change din on the next two cycles -> stamps 0xFFFF then 0x0000.
- Reset asserted with 3 events queued and out_valid=1 -> next cycle out_valid=0, out_level=0, overflow and drop_count cleared.
